// File: rtl/llr_pack_buf.sv
// llr_pack_buf: channel-side input stage of the decoder.
// Saturates serial channel LLRs to the internal width and packs LLR_NUM of
// them into one process-unit vector. Two ping-pong banks let the channel keep
// streaming while the downstream holds a vector. The last vector of each code
// frame is tagged with out_last.
module llr_pack_buf #(
  parameter int LLR_NUM   = 16,
  parameter int LLR_W     = 6,
  parameter int CH_W      = 8,
  parameter int FRAME_LEN = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [CH_W-1:0]    in_llr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LLR_NUM*LLR_W-1:0]  out_llr,
  output logic                      out_last
);

  localparam int VEC_BITS  = LLR_NUM * LLR_W;
  localparam int VECS      = FRAME_LEN / LLR_NUM;
  localparam int FILL_W    = (LLR_NUM > 1) ? $clog2(LLR_NUM) : 1;
  localparam int CNT_W     = (VECS > 1) ? $clog2(VECS) : 1;
  localparam int SAT_MAX   = (1 << (LLR_W - 1)) - 1;

  // Symmetric clamp bounds expressed at the channel width.
  localparam logic signed [CH_W-1:0] CH_MAX = CH_W'(SAT_MAX);
  localparam logic signed [CH_W-1:0] CH_MIN = CH_W'(-SAT_MAX);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LLR_NUM - 1);
  localparam logic [CNT_W-1:0]  VEC_LAST  = CNT_W'(VECS - 1);

  // Ping-pong storage and its bookkeeping.
  logic [VEC_BITS-1:0] bank_q [2];
  logic [VEC_BITS-1:0] bank_d [2];
  logic [1:0]          full_q, full_d;
  logic                wr_sel_q, wr_sel_d;
  logic                rd_sel_q, rd_sel_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    vec_q, vec_d;

  logic signed [CH_W-1:0] clamp_ch;
  logic [LLR_W-1:0]       sat_llr;
  logic                   accept;
  logic                   drain;
  logic                   complete;

  // Clamp the channel LLR symmetrically so the most-negative code never appears.
  always_comb begin
    if (in_llr > CH_MAX) begin
      clamp_ch = CH_MAX;
    end else if (in_llr < CH_MIN) begin
      clamp_ch = CH_MIN;
    end else begin
      clamp_ch = in_llr;
    end
  end

  assign sat_llr = clamp_ch[LLR_W-1:0];

  // All handshake outputs come from registered state only; out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = ~full_q[wr_sel_q];
  assign out_valid = full_q[rd_sel_q];
  assign out_llr   = bank_q[rd_sel_q];
  assign out_last  = out_valid && (vec_q == VEC_LAST);

  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign complete = accept && (fill_q == FILL_LAST);

  // Next-state: pack accepted LLRs, flip banks on completion and on drain.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch); blocking '=' is correct in combinational code.
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    full_d    = full_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    fill_d    = fill_q;
    vec_d     = vec_q;

    if (accept) begin
      // Slot k sits at the MSB end for k=0, so it occupies LSB chunk LLR_NUM-1-k.
      bank_d[wr_sel_q][(LLR_NUM - 1 - int'(fill_q)) * LLR_W +: LLR_W] = sat_llr;
      fill_d = complete ? '0 : fill_q + 1'b1;
    end

    // A completing bank is never the draining bank: completion needs
    // full[wr_sel]=0 and drain needs full[rd_sel]=1, so both may fire together.
    if (complete) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end

    if (drain) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
      vec_d            = (vec_q == VEC_LAST) ? '0 : vec_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values of the others.
    if (!rst_n) begin
      // NOTE: bank storage is reset explicitly so out_llr never carries X,
      // even before the first vector has been written.
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      full_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      fill_q    <= '0;
      vec_q     <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      full_q    <= full_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      fill_q    <= fill_d;
      vec_q     <= vec_d;
    end
  end

endmodule

// File: doc/llr_pack_buf.md
Name: llr_pack_buf

Overview:
- Channel-side input stage of the decoder. Sits directly upstream of the processing unit, including the repetition node, and feeds its LLR bus.
- Accepts channel LLRs serially, one per cycle, and saturates each to the internal LLR width.
- Packs LLR_NUM consecutive LLRs into one process-unit vector. Ping-pong double-buffering lets the channel keep streaming while the downstream holds a vector.
- Tags the last vector of each code frame.

Parameters:
- LLR_NUM, 16: LLRs per output vector; matches the process-unit LLR count.
- LLR_W, 6: internal LLR width, two's complement.
- CH_W, 8: channel LLR width, two's complement; CH_W >= LLR_W.
- FRAME_LEN, 1024: LLRs per code frame; must be a multiple of LLR_NUM.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: channel LLR valid.
- in_ready, output, 1: buffer can accept a channel LLR.
- in_llr, input, CH_W: channel LLR, signed.
- out_valid, output, 1: packed vector available.
- out_ready, input, 1: downstream accepts the vector.
- out_llr, output, LLR_NUM*LLR_W: packed LLR vector.
- out_last, output, 1: the current out_llr is the final vector of the frame.

Behaviour:
- Clock and reset: single clock clk, rising edge. Reset rst_n is synchronous and active-low.
- Reset values: out_valid=0, out_last=0, out_llr=0, in_ready=1. Also cleared by reset: fill counter, vector counter, both bank-full flags, wr_sel=0, rd_sel=0.
- Saturation (combinational on input): symmetric clamp to [-(2^(LLR_W-1)-1), +(2^(LLR_W-1)-1)], then truncate to LLR_W.
  - Default range is [-31, +31].
  - The most-negative internal code 6'b100000 is never produced. Downstream sign-extension sums therefore cannot overflow asymmetrically.
- Accept rule: an LLR is accepted on a cycle with in_valid && in_ready.
- Packing into bank[wr_sel]:
  - The k-th accepted LLR of a vector (k = 0..LLR_NUM-1) goes to slot k.
  - Slot k occupies bits [(LLR_NUM-k)*LLR_W-1 -: LLR_W]; slot 0 is at the MSB end.
  - The fill counter increments on each accept.
- Bank completion: on acceptance of slot LLR_NUM-1:
  - bank[wr_sel] full flag is set;
  - wr_sel toggles;
  - the fill counter wraps to 0.
- in_ready = !full[wr_sel], registered state only. There is no combinational path from out_ready to in_ready.
- Output: out_valid = full[rd_sel]; out_llr = bank[rd_sel]; out_last derives from the output vector counter.
  - All three are held stable while out_valid && !out_ready.
- Drain: on out_valid && out_ready:
  - full[rd_sel] is cleared and rd_sel toggles;
  - the vector counter increments and wraps to 0 after FRAME_LEN/LLR_NUM-1.
- out_last = out_valid && (vector counter == FRAME_LEN/LLR_NUM-1).
- Latency: if the LLR_NUM-th LLR is accepted at edge t and the target bank was empty-drained, out_valid is high after edge t (visible in cycle t+1). Latency is 1 cycle from the final accept.
- Throughput: 1 LLR/cycle sustained when out_ready is high at least 1 in every LLR_NUM cycles.
- Simultaneous completion and drain: bank A completing and bank B draining in the same cycle both take effect.
  - wr_sel and rd_sel each toggle independently.
  - No LLR is lost and no vector is duplicated.
- Both banks full: in_ready=0. in_llr is ignored even if in_valid=1.
  - in_ready returns to 1 the cycle after the drain handshake frees bank[wr_sel].
- in_valid deassertion mid-vector: the partial fill is retained indefinitely, with no timeout and no padding.
- Reset mid-operation: partial fills and pending vectors are discarded, and out_valid drops on the reset edge.
  - Frame alignment restarts at slot 0 of vector 0.
- No X propagation: bank contents are reset to 0.

Test Plan:
1. Sequential fill: feed in_llr = 1..16 with out_ready=1 → one vector whose slot 0 (bits [95:90]) = 6'd1 and slot 15 (bits [5:0]) = 6'd16. out_valid is high exactly 1 cycle after the 16th accept and pulses for 1 cycle.
2. Saturation: in_llr = 127, -128, 31, -32, -3, 0 → slots = 6'b011111, 6'b100001, 6'b011111, 6'b100001, 6'b111101, 6'b000000.
3. Backpressure: out_ready=0 with continuous in_valid → 32 LLRs accepted, then in_ready=0 and in_llr ignored; out_llr stays frozen on vector 0.
   Raising out_ready for 1 cycle → vector 0 delivered, in_ready=1 on the next cycle, and vector 1 is presented next, in order.
4. Frame tagging: stream 2*FRAME_LEN LLRs with out_ready=1 → out_last high only on vectors 63 and 127, i.e. exactly 2 pulses; the counter wraps cleanly.
5. Simultaneous events: arrange the 16th accept into bank 1 in the same cycle as the drain of bank 0 → both flags update and the output order is 0 then 1; no gap and no duplicate.
6. Reset mid-vector: assert rst_n=0 for 1 cycle after 7 accepts with a full bank pending → out_valid=0 and in_ready=1 after the edge.
   A subsequent 16 LLRs form the first output vector, starting at slot 0, with out_last counting from vector 0.
